// File: rtl/secure_mem_initiator.sv
// secure_mem_initiator: requester-side controller for the secure key memory.
// Takes one read/write command at a time over a valid/ready channel, drives
// single-cycle memory strobes and returns one response per command. It rejects
// out-of-range addresses and times out reads that the memory never answers.
// All outputs are registered. The memory address/data bus is zeroed whenever
// no strobe is active.
module secure_mem_initiator #(
    parameter int WIDTH   = 256,
    parameter int LENGTH  = 6,
    parameter int TIMEOUT = 15,
    localparam int AW     = (LENGTH > 1) ? $clog2(LENGTH) : 1,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wrData,
    input  logic [WIDTH-1:0] mem_rdData,
    input  logic             mem_rdData_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Number of words, widened by one bit so LENGTH itself is representable.
    localparam logic [AW:0]   LEN_W    = (AW + 1)'(LENGTH);
    // Last wait-counter value before the read is declared lost.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic               cmd_ready_reg;
    logic               rsp_valid_reg;
    logic [WIDTH-1:0]   rsp_data_reg;
    logic               rsp_error_reg;
    logic               mem_rd_en_reg;
    logic               mem_wr_en_reg;
    logic [AW-1:0]      mem_addr_reg;
    logic [WIDTH-1:0]   mem_wrdata_reg;

    logic               addr_bad;

    // Range check on the incoming address.
    assign addr_bad = ({1'b0, cmd_addr} >= LEN_W);

    // Command FSM. Strobes and the memory bus default to zero each cycle, so
    // each strobe lasts exactly one cycle and no key data lingers on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            cmd_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_error_reg  <= 1'b0;
            mem_rd_en_reg  <= 1'b0;
            mem_wr_en_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wrdata_reg <= '0;
        end else begin
            mem_rd_en_reg  <= 1'b0;
            mem_wr_en_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wrdata_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        if (addr_bad) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_error_reg <= 1'b1;
                            rsp_data_reg  <= '0;
                        end else if (cmd_write) begin
                            state_reg      <= ST_WRITE;
                            mem_wr_en_reg  <= 1'b1;
                            mem_addr_reg   <= cmd_addr;
                            mem_wrdata_reg <= cmd_wdata;
                        end else begin
                            state_reg     <= ST_READ;
                            mem_rd_en_reg <= 1'b1;
                            mem_addr_reg  <= cmd_addr;
                        end
                    end
                end
                ST_WRITE: begin
                    state_reg     <= ST_RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_error_reg <= 1'b0;
                    rsp_data_reg  <= '0;
                end
                ST_READ: begin
                    state_reg <= ST_WAIT;
                    cnt_reg   <= '0;
                end
                ST_WAIT: begin
                    if (mem_rdData_valid) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_error_reg <= 1'b0;
                        rsp_data_reg  <= mem_rdData;
                    end else if (cnt_reg >= CNT_LAST) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_error_reg <= 1'b1;
                        rsp_data_reg  <= '0;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        cmd_ready_reg <= 1'b1;
                        rsp_valid_reg <= 1'b0;
                        rsp_error_reg <= 1'b0;
                        rsp_data_reg  <= '0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                    rsp_error_reg <= 1'b0;
                    rsp_data_reg  <= '0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_error  = rsp_error_reg;
    assign mem_rd_en  = mem_rd_en_reg;
    assign mem_wr_en  = mem_wr_en_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wrData = mem_wrdata_reg;

endmodule

// File: tb/tb_secure_mem_initiator.sv
// Testbench for secure_mem_initiator: table of directed commands with expected
// response latency/data/error, plus hand-written backpressure and mid-read
// reset sequences, against a small key-memory model.
module tb_secure_mem_initiator;

    localparam int WIDTH   = 256;
    localparam int LENGTH  = 6;
    localparam int TIMEOUT = 15;
    localparam int AW      = 3;

    localparam logic [WIDTH-1:0] KEY  = 256'h49361d1ee0abd2c572b0edf565a9984c3ed4923ab2f88cd6b0eaa30d0c13ef1b;
    localparam logic [WIDTH-1:0] A5   = {32{8'hA5}};
    localparam logic [WIDTH-1:0] PAT0 = {8{32'hDEADBEEF}};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [AW-1:0]    cmd_addr = '0;
    logic [WIDTH-1:0] cmd_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_error;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wrData;
    logic [WIDTH-1:0] mem_rdData = '0;
    logic             mem_rdData_valid = 1'b0;

    int tests = 0;
    int fails = 0;
    int bus_viol = 0;
    logic nomem = 1'b0;

    always #5 clk = ~clk;

    secure_mem_initiator #(.WIDTH(WIDTH), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wrData(mem_wrData), .mem_rdData(mem_rdData),
        .mem_rdData_valid(mem_rdData_valid)
    );

    // Memory model: key at word 2, one-cycle read latency, optional silence.
    logic [WIDTH-1:0] mem [LENGTH];
    initial begin
        for (int i = 0; i < LENGTH; i++) mem[i] = '0;
        mem[2] = KEY;
    end
    always @(posedge clk) begin
        mem_rdData_valid <= mem_rd_en && !nomem;
        mem_rdData       <= (mem_rd_en && int'(mem_addr) < LENGTH) ? mem[mem_addr] : '0;
        if (mem_wr_en && int'(mem_addr) < LENGTH) mem[mem_addr] <= mem_wrData;
    end

    // Bus monitor: no overlapping strobes, no back-to-back strobes, clean idle bus.
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge clk) begin
        if (mem_rd_en && mem_wr_en) bus_viol++;
        if ((mem_rd_en && prev_rd) || (mem_wr_en && prev_wr)) bus_viol++;
        if (!mem_rd_en && !mem_wr_en && (mem_addr != '0 || mem_wrData != '0)) bus_viol++;
        prev_rd = mem_rd_en;
        prev_wr = mem_wr_en;
    end

    task automatic check(input string name, input logic ok,
                         input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string            name;
        logic             write;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
        logic             nomem;
        logic             exp_err;
        logic [WIDTH-1:0] exp_data;
        int               exp_lat;
        int               exp_rd;
        int               exp_wr;
    } vec_t;

    vec_t vecs[10];

    // Issue one command, measure response latency (cycles after the accepting
    // edge), check the response and the strobes, then consume it.
    task automatic do_cmd(input vec_t v);
        int g, k, rd_cnt, wr_cnt, strobe_k;
        g = 0; k = 1; rd_cnt = 0; wr_cnt = 0; strobe_k = 0;
        @(negedge clk);
        nomem     = v.nomem;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({v.name, " accept"}, cmd_ready, WIDTH'(cmd_ready), WIDTH'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = '0;
        forever begin
            if ((mem_rd_en || mem_wr_en) && strobe_k == 0) strobe_k = k;
            rd_cnt += int'(mem_rd_en);
            wr_cnt += int'(mem_wr_en);
            if (rsp_valid || k >= 40) break;
            @(negedge clk);
            k++;
        end
        check({v.name, " latency"}, k == v.exp_lat, WIDTH'(k), WIDTH'(v.exp_lat));
        check({v.name, " data"}, rsp_data == v.exp_data, rsp_data, v.exp_data);
        check({v.name, " error"}, rsp_error == v.exp_err, WIDTH'(rsp_error), WIDTH'(v.exp_err));
        check({v.name, " rd_cnt"}, rd_cnt == v.exp_rd, WIDTH'(rd_cnt), WIDTH'(v.exp_rd));
        check({v.name, " wr_cnt"}, wr_cnt == v.exp_wr, WIDTH'(wr_cnt), WIDTH'(v.exp_wr));
        check({v.name, " strobe_cycle"}, strobe_k == ((v.exp_rd + v.exp_wr) > 0 ? 1 : 0),
              WIDTH'(strobe_k), WIDTH'((v.exp_rd + v.exp_wr) > 0 ? 1 : 0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({v.name, " consumed"}, !rsp_valid && cmd_ready && rsp_data == '0,
              {rsp_valid, cmd_ready}, WIDTH'(2'b01));
        nomem = 1'b0;
        $display("[TB] %s: write=%0b addr=%0d err=%0b latency=%0d", v.name, v.write, v.addr, v.exp_err, k);
    endtask

    initial begin
        logic stable;
        logic seen;
        int   g;

        vecs[0] = '{"rd_key",     1'b0, 3'd2, '0,   1'b0, 1'b0, KEY,  3,  1, 0};
        vecs[1] = '{"wr_a5",      1'b1, 3'd4, A5,   1'b0, 1'b0, '0,   2,  0, 1};
        vecs[2] = '{"rd_a5",      1'b0, 3'd4, '0,   1'b0, 1'b0, A5,   3,  1, 0};
        vecs[3] = '{"rd_addr6",   1'b0, 3'd6, '0,   1'b0, 1'b1, '0,   1,  0, 0};
        vecs[4] = '{"wr_addr6",   1'b1, 3'd6, A5,   1'b0, 1'b1, '0,   1,  0, 0};
        vecs[5] = '{"rd_addr7",   1'b0, 3'd7, '0,   1'b0, 1'b1, '0,   1,  0, 0};
        vecs[6] = '{"wr_addr7",   1'b1, 3'd7, A5,   1'b0, 1'b1, '0,   1,  0, 0};
        vecs[7] = '{"rd_timeout", 1'b0, 3'd1, '0,   1'b1, 1'b1, '0,   TIMEOUT + 2, 1, 0};
        vecs[8] = '{"wr_addr0",   1'b1, 3'd0, PAT0, 1'b0, 1'b0, '0,   2,  0, 1};
        vecs[9] = '{"rd_addr0",   1'b0, 3'd0, '0,   1'b0, 1'b0, PAT0, 3,  1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {cmd_ready, rsp_valid, rsp_error, mem_rd_en, mem_wr_en} == 5'b0 &&
              rsp_data == '0 && mem_addr == '0 && mem_wrData == '0,
              {cmd_ready, rsp_valid, rsp_error, mem_rd_en, mem_wr_en}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready == 1'b1, WIDTH'(cmd_ready), WIDTH'(1));

        for (int i = 0; i < 10; i++) do_cmd(vecs[i]);

        // Backpressure: response held 5 cycles with cmd_valid high throughout
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        cmd_addr = 3'd4;
        g = 0;
        while (!rsp_valid && g < 40) begin @(negedge clk); g++; end
        check("hold rsp_data", rsp_valid && rsp_data == KEY, rsp_data, KEY);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stable &= rsp_valid && rsp_data == KEY && !rsp_error && !cmd_ready;
        end
        check("hold stable", stable, WIDTH'(stable), WIDTH'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold released", cmd_ready && !rsp_valid, {cmd_ready, rsp_valid}, WIDTH'(2'b10));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold next_accept", mem_rd_en && mem_addr == 3'd4 && !cmd_ready,
              {mem_rd_en, cmd_ready, mem_addr}, {1'b1, 1'b0, 3'd4});
        g = 0;
        while (!rsp_valid && g < 40) begin @(negedge clk); g++; end
        check("hold next_data", rsp_valid && rsp_data == A5 && !rsp_error, rsp_data, A5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("[TB] backpressure: held 5 cycles, next read accepted one cycle after release");

        // Reset while waiting for read data
        nomem = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd3;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nomem = 1'b0;
        check("wait_reset_outputs",
              {cmd_ready, rsp_valid, rsp_error, mem_rd_en, mem_wr_en} == 5'b0 &&
              rsp_data == '0 && mem_addr == '0 && mem_wrData == '0,
              {cmd_ready, rsp_valid, rsp_error, mem_rd_en, mem_wr_en}, '0);
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        check("no_rsp_after_abort", !seen, WIDTH'(seen), '0);
        $display("[TB] reset in WAIT: aborted read dropped");
        do_cmd(vecs[0]);

        check("bus_rules", bus_viol == 0, WIDTH'(bus_viol), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/secure_mem_initiator.md
# secure_mem_initiator

Requester-side controller for the secure key memory. It accepts single-word read and write commands from a crypto or key-management client over a valid/ready command channel. It drives the memory's rd_en/wr_en/addr/wrData strobes, collects rdData when rdData_valid is asserted, and returns one response per command over a valid/ready response channel. It sits between the secure-communication engine and the secure memory, and adds address-range checking and a read timeout.

## Interface
- WIDTH, 256, data word width; must match the memory.
- LENGTH, 6, number of memory words; address width AW = $clog2(LENGTH).
- TIMEOUT, 15, maximum cycles spent waiting for mem_rdData_valid before an error response.

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  word address.
- cmd_wdata  in  WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  client accepts response.
- rsp_data  out  WIDTH  read data; 0 for writes and errors.
- rsp_error  out  1  1 = out-of-range address or read timeout.
- mem_rd_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wrData  out  WIDTH  memory write data.
- mem_rdData  in  WIDTH  memory read data.
- mem_rdData_valid  in  1  memory read data valid.

## Operation
- States:
  - IDLE
  - WRITE
  - READ
  - WAIT
  - RESP
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register cmd_write, cmd_addr and cmd_wdata.
  - cmd_addr >= LENGTH → RESP with rsp_error=1, rsp_data=0. No memory strobe is issued.
  - Otherwise: cmd_write=1 → WRITE; cmd_write=0 → READ.
- WRITE: mem_wr_en=1, mem_addr and mem_wrData driven for exactly one cycle, then RESP with error=0, data=0.
- READ: mem_rd_en=1 and mem_addr driven for exactly one cycle, then WAIT. The wait counter clears to 0.
- WAIT: each cycle, if mem_rdData_valid=1, capture mem_rdData into rsp_data, set error=0 and go to RESP. Otherwise the counter increments.
- WAIT timeout: when the counter reaches TIMEOUT-1 with no valid, go to RESP with error=1, data=0.
- mem_rdData_valid is ignored in every state except WAIT.
- RESP: rsp_valid=1. rsp_data and rsp_error are held stable until rsp_valid&&rsp_ready, then the block returns to IDLE.
- cmd_ready=0 in every state except IDLE. Commands are never queued; one command is outstanding at a time.
- mem_rd_en and mem_wr_en are never high together, and neither is ever high for more than one consecutive cycle.
- mem_addr and mem_wrData are 0 whenever no strobe is active, so no key material lingers on the memory bus.
- rsp_data is cleared to 0 on leaving RESP.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset: at the first clock edge with rst=1, state becomes IDLE.
  - Outputs forced to 0: cmd_ready, rsp_valid, rsp_data, rsp_error, mem_rd_en, mem_wr_en, mem_addr, mem_wrData.
  - cmd_ready rises in the first cycle after the edge at which rst is sampled 0.
- Reset mid-operation (any state): the pending command and any pending response are dropped. A strobe active in that cycle deasserts after the edge. No response is produced for the dropped command.
- All outputs are registered.
- Command accepted at edge T:
  - Write: mem_wr_en high in cycle T+1; rsp_valid high from cycle T+2.
  - Read with a memory that returns data one cycle after rd_en: mem_rd_en high in T+1, mem_rdData_valid sampled in T+2, rsp_valid high from T+3.
  - Out-of-range address: rsp_valid high from T+1.
  - Read timeout: rsp_valid (error=1) high from T+2+TIMEOUT.
- Response consumed at edge R (rsp_valid&&rsp_ready): rsp_valid=0 and cmd_ready=1 in cycle R+1. The next command can be accepted at edge R+1.
- rsp_ready high in the first RESP cycle costs no extra cycle; the minimum read period is 4 cycles.
- cmd_valid may stay high across the response; the command is accepted only in IDLE.

## Test plan
- After reset, with a memory model preloaded with the key at word 2: read addr 2. Expect mem_rd_en for exactly one cycle at T+1, rsp_valid at T+3, rsp_data=256'h49361d1ee0abd2c572b0edf565a9984c3ed4923ab2f88cd6b0eaa30d0c13ef1b, rsp_error=0.
- Write 256'hA5…A5 (all bytes A5) to addr 4, then read addr 4. Expect a write response at T+2 with data=0 and error=0, and a read response returning 256'hA5…A5. mem_wr_en and mem_rd_en must never overlap.
- Command to addr 6 and to addr 7 (read and write). Expect rsp_error=1, rsp_data=0 at T+1, with mem_rd_en and mem_wr_en low throughout.
- Memory model that never asserts mem_rdData_valid, read addr 1. Expect rsp_valid with error=1, data=0 exactly at T+2+TIMEOUT (cycle T+17 with the default TIMEOUT=15).
- Hold rsp_ready=0 for 5 cycles after a read response is presented, with cmd_valid held high. Expect rsp_data and rsp_error stable and cmd_ready=0 throughout. When rsp_ready rises, the next command is accepted one cycle later.
- Assert rst for one cycle while in WAIT. Expect all outputs 0 after that edge, no response for the aborted read, and a subsequent read of addr 2 that completes normally.
